// File: rtl/uart_rx_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_mmio_pkg
// Description : Shared constants for the UART receiver: status bit indices,
//               deserialiser state encoding and read-data padding width.
//               UART_RX_PARITY_EN adds the PARITY state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_mmio_pkg;

    localparam int ST_VALID = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVR   = 2;
    localparam int ST_FERR  = 3;
    localparam int ST_PERR  = 4;
    localparam int ST_W     = 5;

    localparam int PAD_W    = 24;

    localparam int STATE_W  = 3;
    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_START  = 3'd1;
    localparam logic [STATE_W-1:0] S_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] S_STOP   = 3'd3;
    localparam logic [STATE_W-1:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [STATE_W-1:0] S_PARITY = 3'd5;
`endif

    // Start-bit half wait, never zero so tiny divisors still resample.
    function automatic int half_bit(input int clks_per_bit);
        return (clks_per_bit / 2 > 0) ? clks_per_bit / 2 : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous FIFO with first-word head output; a push while
//               full is accepted only when a pop frees a slot in that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_full_count);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_mmio
// Description : UART receiver with RX FIFO and zero-latency MMIO read data
//               and status registers. Define UART_RX_PARITY_EN for even parity.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_mmio
    import uart_rx_mmio_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        uart_rx_read_en,
    input  logic        uart_status_read_en,
    output logic [31:0] uart_rx_read_data,
    output logic [31:0] uart_status_read_data
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int FCNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(half_bit(CLKS_PER_BIT) - 1);

    logic               r_rx_meta, r_rx_sync;
    logic [STATE_W-1:0] r_state, w_state_next;
    logic [CNT_W-1:0]   r_clk_cnt, w_cnt_next;
    logic [2:0]         r_bit_cnt, w_bit_next;
    logic [7:0]         r_shift, w_shift_next;
    logic               r_rd_en_d, r_st_en_d;
    logic               r_ovr, r_ferr;
    logic               w_push, w_pop_req, w_st_clr;
    logic               w_ferr_evt, w_ovr_evt, w_perr_flag;
    logic [7:0]         w_head;
    logic [FCNT_W-1:0]  w_count;
    logic               w_full, w_empty;
    logic [ST_W-1:0]    w_status;
`ifdef UART_RX_PARITY_EN
    logic               r_par_bad, w_par_bad_next;
    logic               r_perr, w_perr_evt;
`endif

    assign w_pop_req = uart_rx_read_en & ~r_rd_en_d;
    assign w_st_clr  = uart_status_read_en & ~r_st_en_d;
    // A pop in the same cycle frees the slot, so only an unpaired push overruns.
    assign w_ovr_evt = w_push & w_full & ~w_pop_req;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_clk_cnt + 1'b1;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_push       = 1'b0;
        w_ferr_evt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_next = r_par_bad;
        w_perr_evt     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                w_bit_next = '0;
`ifdef UART_RX_PARITY_EN
                w_par_bad_next = 1'b0;
`endif
                if (!r_rx_sync) w_state_next = S_START;
            end
            S_START: begin
                if (r_clk_cnt == c_half_last) begin
                    w_cnt_next   = '0;
                    w_state_next = r_rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_clk_cnt == c_bit_last) begin
                    w_cnt_next   = '0;
                    w_shift_next = {r_rx_sync, r_shift[7:1]};
                    w_bit_next   = r_bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (r_bit_cnt == 3'd7) w_state_next = S_PARITY;
`else
                    if (r_bit_cnt == 3'd7) w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_clk_cnt == c_bit_last) begin
                    w_cnt_next     = '0;
                    w_par_bad_next = (r_rx_sync != ^r_shift);
                    w_perr_evt     = w_par_bad_next;
                    w_state_next   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_clk_cnt == c_bit_last) begin
                    w_cnt_next = '0;
                    if (r_rx_sync) begin
`ifdef UART_RX_PARITY_EN
                        w_push = ~r_par_bad;
`else
                        w_push = 1'b1;
`endif
                        w_state_next = S_IDLE;
                    end else begin
                        w_ferr_evt   = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_next = '0;
                if (r_rx_sync) w_state_next = S_IDLE;
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rd_en_d <= 1'b0;
            r_st_en_d <= 1'b0;
            r_ovr     <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_state   <= w_state_next;
            r_clk_cnt <= w_cnt_next;
            r_bit_cnt <= w_bit_next;
            r_shift   <= w_shift_next;
            r_rd_en_d <= uart_rx_read_en;
            r_st_en_d <= uart_status_read_en;
            // An error event in the clear cycle keeps its flag set.
            r_ovr     <= w_ovr_evt  | (r_ovr  & ~w_st_clr);
            r_ferr    <= w_ferr_evt | (r_ferr & ~w_st_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_par_bad <= w_par_bad_next;
            r_perr    <= w_perr_evt | (r_perr & ~w_st_clr);
        end
    end
    assign w_perr_flag = r_perr;
`else
    assign w_perr_flag = 1'b0;
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop       (w_pop_req),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        w_status           = '0;
        w_status[ST_VALID] = (w_count != '0);
        w_status[ST_FULL]  = w_full;
        w_status[ST_OVR]   = r_ovr;
        w_status[ST_FERR]  = r_ferr;
        w_status[ST_PERR]  = w_perr_flag;
    end

    assign uart_status_read_data = {{(32 - ST_W){1'b0}}, w_status};
    assign uart_rx_read_data     = w_empty ? 32'd0 : {{PAD_W{1'b0}}, w_head};

endmodule
`default_nettype wire
